// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: IMEM request/response channel, execute redirect, and the head of the
// prefetch queue presented to decode.
interface fetch_prefetch_queue_if #(
  parameter int XLEN = 32
);
  // Handshake rules:
  // - A request transfers on a cycle where IMEM_req_o && IMEM_ready_i.
  // - IMEM_valid_i marks one response, returned in request order. IMEM has no back-pressure.
  // - The head entry transfers to decode on a cycle where PIP_valid_o && !stall_i.
  logic            IMEM_req_o;
  logic [XLEN-1:0] IMEM_addr_o;
  logic            IMEM_ready_i;
  logic            IMEM_valid_i;
  logic [XLEN-1:0] IMEM_data_i;
  logic            PIP_pc_load_i;
  logic [XLEN-1:0] PIP_target_address_i;
  logic            stall_i;
  logic            PIP_valid_o;
  logic [XLEN-1:0] PIP_instruction_o;
  logic [XLEN-1:0] PIP_pc_o;
  logic            PIP_TRAP_o;

  modport master (
    output IMEM_req_o, IMEM_addr_o, PIP_valid_o, PIP_instruction_o, PIP_pc_o, PIP_TRAP_o,
    input  IMEM_ready_i, IMEM_valid_i, IMEM_data_i, PIP_pc_load_i, PIP_target_address_i, stall_i
  );

  modport slave (
    input  IMEM_req_o, IMEM_addr_o, PIP_valid_o, PIP_instruction_o, PIP_pc_o, PIP_TRAP_o,
    output IMEM_ready_i, IMEM_valid_i, IMEM_data_i, PIP_pc_load_i, PIP_target_address_i, stall_i
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage that issues sequential IMEM fetches ahead of decode into an in-order prefetch
// queue, drops stale responses after a redirect, and flags misaligned redirect targets.
module fetch_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] START_ADDR      = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [DEPTH-1:0] trap_q;

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic            halted;

  logic redirect;
  logic misaligned;
  logic head_valid;
  logic issue;
  logic rsp_fire;
  logic push;
  logic pop;

  assign redirect   = bus.PIP_pc_load_i;
  assign misaligned = bus.PIP_target_address_i[1:0] != 2'b00;
  assign head_valid = count != '0;

  // Every in-flight request holds a queue slot, so a response can always be written.
  assign bus.IMEM_req_o  = !reset && !halted && !redirect
                           && (int'(count) + int'(outstanding) < DEPTH)
                           && (int'(outstanding) < MAX_OUTSTANDING);
  assign bus.IMEM_addr_o = fetch_pc;

  assign issue    = bus.IMEM_req_o && bus.IMEM_ready_i;
  assign rsp_fire = bus.IMEM_valid_i && (outstanding != '0);
  assign push     = rsp_fire && (discard == '0) && !redirect;
  assign pop      = head_valid && !bus.stall_i && !redirect;

  assign bus.PIP_valid_o       = head_valid;
  assign bus.PIP_instruction_o = head_valid ? data_q[head] : NOP;
  assign bus.PIP_pc_o          = head_valid ? pc_q[head] : '0;
  assign bus.PIP_TRAP_o        = head_valid && trap_q[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= START_ADDR;
      rsp_pc      <= START_ADDR;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(rsp_fire);
      if (redirect) begin
        // Everything still in flight belongs to the old stream and must be dropped.
        discard  <= outstanding - OW'(rsp_fire);
        fetch_pc <= bus.PIP_target_address_i;
        rsp_pc   <= bus.PIP_target_address_i;
        halted   <= misaligned;
        head     <= '0;
        if (misaligned) begin
          tail  <= PW'(1);
          count <= CW'(1);
        end else begin
          tail  <= '0;
          count <= '0;
        end
      end else begin
        if (rsp_fire && (discard != '0)) begin
          discard <= discard - OW'(1);
        end
        if (issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          tail   <= tail + PW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage carries no reset; the head is masked by head_valid on the outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (redirect) begin
        if (misaligned) begin
          data_q[0] <= NOP;
          pc_q[0]   <= bus.PIP_target_address_i;
          trap_q[0] <= 1'b1;
        end
      end else if (push) begin
        data_q[tail] <= bus.IMEM_data_i;
        pc_q[tail]   <= rsp_pc;
        trap_q[tail] <= 1'b0;
      end
    end
  end
endmodule
